// File: rtl/disp_pkg.sv
// Shared definitions for the display VRAM fetch path: FSM state encoding,
// AXI read-channel constants and the 2 KB burst alignment helper.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ADDR = 2'd2,
        DATA = 2'd3
    } vram_state_t;

    localparam logic [2:0]  ARSIZE_8B    = 3'b011;
    localparam logic [1:0]  ARBURST_INCR = 2'b01;
    localparam logic [31:0] BURST_BYTES  = 32'd2048;

    // Frame bases are forced onto a burst boundary so no burst crosses 4 KB.
    function automatic logic [31:0] align_base(input logic [31:0] addr);
        return addr & ~(BURST_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/disp_vramctrl_addrgen.sv
// Burst address register, burst counter and last-burst flag for one frame.
// load restarts at a new base; advance steps to the next burst.
module disp_vramctrl_addrgen
    import disp_pkg::*;
#(
    parameter int unsigned NBURST = 600,
    parameter logic [31:0] STEP   = 32'd2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] base,
    output logic [31:0] addr,
    output logic        last
);

    localparam int unsigned CW = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBURST - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;

    assign cnt_nxt_s = cnt_r + CW'(1'b1);

    // Address and burst-count state; last flags the final burst of the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr  <= 32'd0;
            cnt_r <= '0;
            last  <= 1'b0;
        end else if (load) begin
            addr  <= base;
            cnt_r <= '0;
            last  <= (LAST_IDX == '0);
        end else if (advance) begin
            addr  <= addr + STEP;
            cnt_r <= cnt_nxt_s;
            last  <= (cnt_nxt_s == LAST_IDX);
        end else begin
            addr  <= addr;
            cnt_r <= cnt_r;
            last  <= last;
        end
    end

endmodule

// File: rtl/disp_vramctrl.sv
// Frame fetch engine: one AXI4 INCR burst at a time from VRAM into the
// display FIFO. Optional sticky overrun detection: DISP_VRAMCTRL_OVERRUN_EN.
module disp_vramctrl
    import disp_pkg::*;
#(
    parameter int unsigned H_PIXELS    = 640,
    parameter int unsigned V_LINES     = 480,
    parameter int unsigned BURST_BEATS = 256
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic        DISPON,
    input  logic        VSTART,
    input  logic [31:0] DISPADDR,
    input  logic        BUF_WREADY,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [63:0] RDATA,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic [63:0] FIFOIN,
    output logic        FIFOWR,
    output logic        BUSY,
    output logic        OVERRUN
);

    localparam int unsigned NBURST = (H_PIXELS * V_LINES) / (2 * BURST_BEATS);
    localparam logic [31:0] STEP   = 32'(BURST_BEATS * 8);

    vram_state_t state_r;
    logic        load_s;
    logic        advance_s;
    logic        last_burst_s;

    assign ARLEN   = 8'(BURST_BEATS - 1);
    assign ARSIZE  = ARSIZE_8B;
    assign ARBURST = ARBURST_INCR;
    assign RREADY  = 1'b1;

    assign load_s    = (state_r == IDLE) && VSTART && DISPON;
    assign advance_s = (state_r == DATA) && RVALID && RLAST;

    disp_vramctrl_addrgen #(
        .NBURST (NBURST),
        .STEP   (STEP)
    ) u_addrgen (
        .clk     (ACLK),
        .rst     (ARST),
        .load    (load_s),
        .advance (advance_s),
        .base    (align_base(DISPADDR)),
        .addr    (ARADDR),
        .last    (last_burst_s)
    );

    // Fetch FSM with registered AXI address valid, FIFO write port and BUSY.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_r <= IDLE;
            ARVALID <= 1'b0;
            FIFOIN  <= 64'd0;
            FIFOWR  <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            FIFOWR <= 1'b0;
            case (state_r)
                IDLE: begin
                    ARVALID <= 1'b0;
                    if (VSTART && DISPON) begin
                        state_r <= WAIT;
                        BUSY    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        BUSY    <= 1'b0;
                    end
                end
                WAIT: begin
                    // Room for a whole burst is required: RREADY never stalls.
                    if (BUF_WREADY) begin
                        state_r <= ADDR;
                        ARVALID <= 1'b1;
                    end else if (!DISPON) begin
                        state_r <= IDLE;
                        BUSY    <= 1'b0;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                ADDR: begin
                    if (ARREADY) begin
                        state_r <= DATA;
                        ARVALID <= 1'b0;
                    end else begin
                        state_r <= ADDR;
                        ARVALID <= 1'b1;
                    end
                end
                DATA: begin
                    if (RVALID) begin
                        FIFOIN <= RDATA;
                        FIFOWR <= 1'b1;
                    end else begin
                        FIFOIN <= FIFOIN;
                    end
                    // DISPON is only honoured at burst end; accepted bursts always drain.
                    if (RVALID && RLAST) begin
                        if (last_burst_s || !DISPON) begin
                            state_r <= IDLE;
                            BUSY    <= 1'b0;
                        end else begin
                            state_r <= WAIT;
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ARVALID <= 1'b0;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

`ifdef DISP_VRAMCTRL_OVERRUN_EN
    // Sticky flag: a new frame started before the previous fetch finished.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            OVERRUN <= 1'b0;
        end else if (VSTART && DISPON && (state_r != IDLE)) begin
            OVERRUN <= 1'b1;
        end else begin
            OVERRUN <= OVERRUN;
        end
    end
`else
    assign OVERRUN = 1'b0;
`endif

endmodule

// File: doc/disp_vramctrl.md
# disp_vramctrl

Reads one display frame per vertical period from VRAM over an AXI4 read channel and pushes the returned 64-bit beats (two 24-bit pixels packed in 32-bit slots) into the display FIFO write port. It sits directly upstream of the display FIFO stage, in the ACLK domain. It issues one 256-beat burst at a time, and only when the FIFO reports room for a full burst.

## Interface
Parameters:
- H_PIXELS, 640, active pixels per line
- V_LINES, 480, active lines per frame
- BURST_BEATS, 256, beats per AXI burst. H_PIXELS*V_LINES/2 must be a multiple of BURST_BEATS.

Ports:
- ACLK  in  1  system clock; the only clock
- ARST  in  1  synchronous, active-high reset
- DISPON  in  1  display enable
- VSTART  in  1  one-cycle frame-start pulse, already synchronized to ACLK
- DISPADDR  in  32  frame base byte address; bits [10:0] ignored (treated as 0)
- BUF_WREADY  in  1  FIFO has ≥256 free entries
- ARADDR  out  32  read address
- ARLEN  out  8  constant BURST_BEATS-1
- ARSIZE  out  3  constant 3'b011
- ARBURST  out  2  constant 2'b01 (INCR)
- ARVALID  out  1  address valid
- ARREADY  in  1  address accepted
- RDATA  in  64  read data
- RLAST  in  1  last beat
- RVALID  in  1  data valid
- RREADY  out  1  tied 1
- FIFOIN  out  64  FIFO write data
- FIFOWR  out  1  FIFO write strobe
- BUSY  out  1  frame fetch in progress
- OVERRUN  out  1  sticky frame-overrun flag (see Configuration)

## Operation
- FSM states: IDLE, WAIT, ADDR, DATA.
- IDLE: when VSTART and DISPON are both 1, latch {DISPADDR[31:11], 11'b0} into the address register, clear the burst counter, and go to WAIT.
- WAIT: if BUF_WREADY is 1, go to ADDR. If DISPON is 0, go to IDLE.
- ADDR: ARVALID=1. Hold ARADDR stable until ARVALID&ARREADY, then go to DATA.
- DATA: each RVALID beat is forwarded to the FIFO. On RVALID&RLAST:
  - add BURST_BEATS*8 bytes to the address and increment the burst counter;
  - if the counter reaches NBURST = H_PIXELS*V_LINES/(2*BURST_BEATS), go to IDLE;
  - else if DISPON is 0, go to IDLE;
  - else go to WAIT.
- An accepted burst is always drained completely. The block never abandons an outstanding AXI transaction.
- Only one burst is outstanding at a time. Because RREADY is constantly 1, FIFO space must be guaranteed by BUF_WREADY before the address is issued.
- Bursts are 2048-byte aligned, so none crosses a 4 KB boundary.
- Address arithmetic is 32-bit and wraps modulo 2^32 (no saturation).
- BUSY = (state != IDLE).
- VSTART arriving while BUSY is ignored for fetch purposes.

## Timing
- All outputs are registered. Reset values: ARVALID=0, ARADDR=0, FIFOIN=0, FIFOWR=0, BUSY=0, OVERRUN=0, state=IDLE, counters=0.
- VSTART sampled in IDLE at cycle t: WAIT at t+1; ARVALID no earlier than t+2 (if BUF_WREADY=1 at t+1).
- Data path: beat accepted at cycle t appears as FIFOIN/FIFOWR at t+1, 1 cycle latency. FIFOWR is high for exactly one cycle per beat.
- After the RLAST beat: next ARVALID no earlier than 2 cycles later (DATA→WAIT→ADDR).
- ARST asserted mid-burst: the FSM returns to IDLE at the next edge and in-flight beats are dropped. System-level requirement: the FIFO and interconnect are reset together with this block.
- VSTART and RLAST in the same cycle: RLAST is processed; VSTART is treated per the busy rule.

## Configuration
- DISP_VRAMCTRL_OVERRUN_EN defined: OVERRUN is set when VSTART=1 while state≠IDLE and DISPON=1. It stays set until ARST.
- Macro undefined: OVERRUN is constant 0 and the detection logic is not compiled.

## Structure
- Shared package disp_pkg holds:
  - the FSM state enum;
  - AXI constants (ARSIZE_8B=3'b011, ARBURST_INCR=2'b01);
  - BURST_BYTES.
- One sub-module, disp_vramctrl_addrgen: the address register, burst counter, and last-burst flag, with load/advance inputs.

## Test plan
- Reset, then DISPADDR=32'h2000_0000, VSTART with DISPON=1 and BUF_WREADY=1, AXI slave always ready → exactly 600 bursts, ARADDR stepping 32'h2000_0000, ..., 32'h2012_B800; 153600 FIFOWR pulses; BUSY falls after the final RLAST.
- BUF_WREADY held 0 for 50 cycles mid-frame → ARVALID stays 0 in WAIT; the next burst issues 1 cycle after BUF_WREADY rises.
- ARREADY delayed 5 cycles → ARADDR and ARVALID stay stable through the wait; handshake completes once.
- DISPON dropped mid-burst → the current 256 beats are all written, then IDLE; a later VSTART restarts from the base.
- VSTART pulsed mid-frame with the macro defined → OVERRUN=1 and sticky, fetch unaffected. With the macro undefined → OVERRUN=0.
- DISPADDR=32'h1000_07FF → first ARADDR is 32'h1000_0000.
